// File: rtl/sub_32bit_seq_if.sv
// Operand/result handshake bundle for the sequential 32-bit subtractor.
//
// Signals:
//   in_valid  - producer has valid operands on A/B
//   in_ready  - subtractor can accept operands
//   A, B      - minuend / subtrahend (32 bits)
//   out_valid - D/B32/OVF hold a finished result
//   out_ready - consumer accepts the result
//   D         - difference A - B mod 2^32
//   B32       - borrow out (A < B unsigned)
//   OVF       - signed overflow of A - B
//
// The master modport is the side that supplies operands and consumes results.
// The slave modport is the subtractor itself.
interface sub_32bit_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A;
    logic [31:0] B;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] D;
    logic        B32;
    logic        OVF;

    modport master (
        output in_valid, A, B, out_ready,
        input  in_ready, out_valid, D, B32, OVF
    );

    modport slave (
        input  in_valid, A, B, out_ready,
        output in_ready, out_valid, D, B32, OVF
    );
endinterface

// File: rtl/sub_32bit_seq.sv
// Multi-cycle 32-bit subtractor, D = A - B.
// Operands are processed one SLICE_W-bit slice per clock, LSB first, with a
// registered borrow between slices. The result is held until consumed.
//
// Parameters:
//   SLICE_W - bits per cycle; one of 1, 2, 4, 8, 16, 32
//
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   bus    - sub_32bit_seq_if slave: operand and result valid/ready handshakes
module sub_32bit_seq #(
    parameter int SLICE_W = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    sub_32bit_seq_if.slave bus
);
    localparam int NSLICE = 32 / SLICE_W;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic               in_ready_q;

    logic [31:0]        a_q;
    logic [31:0]        b_q;
    logic [31:0]        d_q;
    logic               borrow_q;
    logic [IDX_W-1:0]   idx_q;
    logic               b32_q;
    logic               ovf_q;

    logic               accept;
    logic               calc;
    logic               last;
    logic               out_valid;

    logic [4:0]         lsb;
    logic [SLICE_W-1:0] a_sl;
    logic [SLICE_W-1:0] b_sl;
    logic [SLICE_W:0]   slice_res;   // {borrow out, slice difference}

    // ------------------------------------------------------------------
    // State register. in_ready is registered so it stays low while in
    // reset and rises only on the first clock edge after release.
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples the pre-edge values regardless of process order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            in_ready_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            in_ready_q <= (state_nxt == IDLE);
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic.
    // ------------------------------------------------------------------
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)        state_nxt = CALC;
            CALC:    if (last)          state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output / control decode.
    // ------------------------------------------------------------------
    always_comb begin
        accept    = 1'b0;
        calc      = 1'b0;
        last      = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: accept = bus.in_valid & in_ready_q;
            CALC: begin
                calc = 1'b1;
                last = (idx_q == LAST_IDX);
            end
            DONE: out_valid = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Slice arithmetic: SLICE_W+1 bits so the borrow out lands in the MSB.
    // ------------------------------------------------------------------
    always_comb begin
        lsb       = 5'(32'(idx_q) * SLICE_W);
        a_sl      = a_q[lsb +: SLICE_W];
        b_sl      = b_q[lsb +: SLICE_W];
        slice_res = {1'b0, a_sl} - {1'b0, b_sl} - (SLICE_W + 1)'(borrow_q);
    end

    // ------------------------------------------------------------------
    // Datapath registers.
    // ------------------------------------------------------------------
    // NOTE: the datapath registers are reset too, because D/B32/OVF must
    // read zero immediately on reset and an aborted operation must leave
    // no trace of its operands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            d_q      <= '0;
            borrow_q <= 1'b0;
            idx_q    <= '0;
            b32_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else if (accept) begin
            a_q      <= bus.A;
            b_q      <= bus.B;
            borrow_q <= 1'b0;
            idx_q    <= '0;
        end else if (calc) begin
            d_q[lsb +: SLICE_W] <= slice_res[SLICE_W-1:0];
            borrow_q            <= slice_res[SLICE_W];
            idx_q               <= idx_q + IDX_W'(1);
            if (last) begin
                b32_q <= slice_res[SLICE_W];
                // Operands of opposite sign and a result whose sign differs
                // from the minuend means the signed difference overflowed.
                ovf_q <= (a_q[31] ^ b_q[31]) & (slice_res[SLICE_W-1] ^ a_q[31]);
            end
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid;
    assign bus.D         = d_q;
    assign bus.B32       = b32_q;
    assign bus.OVF       = ovf_q;

endmodule
